// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limit and subtractor FSM states
package bcd_pkg;
    typedef logic [3:0] bcd_digit_t;
    localparam bcd_digit_t BCD_MAX = 4'd9;
    typedef enum logic [2:0] {IDLE, CHECK, ONES, TENS, DONE} state_t;
endpackage

// File: rtl/bcd_2d_sub_if.sv
// bcd_2d_sub_if: operand request and result bundle for the two-digit BCD subtractor
interface bcd_2d_sub_if;
    import bcd_pkg::*;
    logic       start;
    bcd_digit_t a_ones;
    bcd_digit_t a_tens;
    bcd_digit_t b_ones;
    bcd_digit_t b_tens;
    logic       busy;
    logic       done;
    logic       neg;
    logic       err;
    bcd_digit_t tens;
    bcd_digit_t ones;
    modport master (output start, a_ones, a_tens, b_ones, b_tens,
                    input  busy, done, neg, err, tens, ones);
    modport slave  (input  start, a_ones, a_tens, b_ones, b_tens,
                    output busy, done, neg, err, tens, ones);
endinterface

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: one decimal digit of a - b - borrow_in with ten's-complement wrap
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       borrow_in,
    output bcd_digit_t diff,
    output logic       borrow_out
);
    logic [4:0] d;
    always_comb begin
        d          = {1'b0, a} - {1'b0, b} - {4'b0, borrow_in};
        borrow_out = d[4];
        diff       = d[4] ? d[3:0] + 4'd10 : d[3:0];
    end
endmodule

// File: rtl/bcd_2d_sub.sv
// bcd_2d_sub: sequential |A - B| on two BCD digits with sign and error flags
module bcd_2d_sub
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    bcd_2d_sub_if.slave s
);
    state_t     state_q, state_d;
    bcd_digit_t a_o_q, a_o_d, a_t_q, a_t_d, b_o_q, b_o_d, b_t_q, b_t_d;
    bcd_digit_t r_ones_q, r_ones_d, tens_q, tens_d, ones_q, ones_d;
    logic       borrow_q, borrow_d, neg_w_q, neg_w_d, neg_q, neg_d, err_q, err_d;
    logic [1:0] hold_q, hold_d;
    bcd_digit_t sa, sb, diff;
    logic       bout, bad, lt;

    // single digit subtractor shared between the ONES and TENS steps
    assign sa = (state_q == TENS) ? a_t_q : a_o_q;
    assign sb = (state_q == TENS) ? b_t_q : b_o_q;
    bcd_digit_sub u_sub (.a(sa), .b(sb), .borrow_in(borrow_q), .diff(diff), .borrow_out(bout));

    assign bad = (a_o_q > BCD_MAX) || (a_t_q > BCD_MAX) || (b_o_q > BCD_MAX) || (b_t_q > BCD_MAX);
    assign lt  = {a_t_q, a_o_q} < {b_t_q, b_o_q};

    always_comb begin
        state_d  = state_q;
        a_o_d    = a_o_q;
        a_t_d    = a_t_q;
        b_o_d    = b_o_q;
        b_t_d    = b_t_q;
        r_ones_d = r_ones_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        borrow_d = borrow_q;
        neg_w_d  = neg_w_q;
        neg_d    = neg_q;
        err_d    = err_q;
        hold_d   = hold_q;
        case (state_q)
            IDLE: if (s.start) begin
                a_o_d   = s.a_ones;
                a_t_d   = s.a_tens;
                b_o_d   = s.b_ones;
                b_t_d   = s.b_tens;
                hold_d  = 2'd0;
                state_d = CHECK;
            end
            CHECK: if (bad) begin
                // idle in CHECK so the error result lands on the same cycle as a normal one
                hold_d = hold_q + 2'd1;
                if (hold_q == 2'd2) begin
                    err_d   = 1'b1;
                    neg_d   = 1'b0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    state_d = DONE;
                end
            end else begin
                a_o_d    = lt ? b_o_q : a_o_q;
                a_t_d    = lt ? b_t_q : a_t_q;
                b_o_d    = lt ? a_o_q : b_o_q;
                b_t_d    = lt ? a_t_q : b_t_q;
                neg_w_d  = lt;
                borrow_d = 1'b0;
                state_d  = ONES;
            end
            ONES: begin
                r_ones_d = diff;
                borrow_d = bout;
                state_d  = TENS;
            end
            TENS: begin
                tens_d  = diff;
                ones_d  = r_ones_q;
                neg_d   = neg_w_q;
                err_d   = 1'b0;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_o_q    <= '0;
            a_t_q    <= '0;
            b_o_q    <= '0;
            b_t_q    <= '0;
            r_ones_q <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
            borrow_q <= 1'b0;
            neg_w_q  <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            a_o_q    <= a_o_d;
            a_t_q    <= a_t_d;
            b_o_q    <= b_o_d;
            b_t_q    <= b_t_d;
            r_ones_q <= r_ones_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            borrow_q <= borrow_d;
            neg_w_q  <= neg_w_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
        end
    end

    assign s.busy = state_q != IDLE;
    assign s.done = state_q == DONE;
    assign s.neg  = neg_q;
    assign s.err  = err_q;
    assign s.tens = tens_q;
    assign s.ones = ones_q;
endmodule

// File: tb/tb_bcd_2d_sub.sv
// tb_bcd_2d_sub: table-driven scoreboard bench for the two-digit BCD subtractor
module tb_bcd_2d_sub;
    import bcd_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_2d_sub_if bus ();
    bcd_2d_sub dut (.clk(clk), .rst_n(rst_n), .s(bus.slave));

    typedef struct {
        logic [3:0] at, ao, bt, bo;
        logic       neg, err;
        logic [3:0] t, o;
    } vec_t;

    vec_t q[$];
    vec_t e;
    vec_t tbl[12];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) check("spurious_done", 1, 0);
            else begin
                e = q.pop_front();
                check("neg", {31'b0, bus.neg}, {31'b0, e.neg});
                check("err", {31'b0, bus.err}, {31'b0, e.err});
                check("tens", {28'b0, bus.tens}, {28'b0, e.t});
                check("ones", {28'b0, bus.ones}, {28'b0, e.o});
            end
        end
    end

    // entered and left at a negedge; on exit the DUT is back in IDLE
    task automatic do_op(input vec_t v, input bit glitch);
        int n;
        q.push_back(v);
        bus.a_tens = v.at;
        bus.a_ones = v.ao;
        bus.b_tens = v.bt;
        bus.b_ones = v.bo;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        check("busy_c1", {31'b0, bus.busy}, 1);
        while (bus.done !== 1'b1 && n < 10) begin
            if (glitch && n == 2) begin
                bus.start  = 1'b1;
                bus.a_tens = 4'd9;
                bus.a_ones = 4'd9;
                bus.b_tens = 4'd0;
                bus.b_ones = 4'd1;
            end
            if (glitch && n == 3) bus.start = 1'b0;
            @(negedge clk);
            n++;
        end
        check("latency", n, 4);
        check("busy_done", {31'b0, bus.busy}, 1);
        @(negedge clk);
        check("busy_idle", {31'b0, bus.busy}, 0);
        check("done_pulse", {31'b0, bus.done}, 0);
    endtask

    initial begin
        vec_t g;
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t g;
        tbl[0]  = '{4'd4, 4'd7, 4'd2, 4'd3, 1'b0, 1'b0, 4'd2, 4'd4};
        tbl[1]  = '{4'd2, 4'd3, 4'd4, 4'd7, 1'b1, 1'b0, 4'd2, 4'd4};
        tbl[2]  = '{4'd5, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 4'd4, 4'd3};
        tbl[3]  = '{4'd0, 4'd0, 4'd9, 4'd9, 1'b1, 1'b0, 4'd9, 4'd9};
        tbl[4]  = '{4'd3, 4'd5, 4'd3, 4'd5, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[5]  = '{4'd4, 4'hA, 4'd2, 4'd3, 1'b0, 1'b1, 4'd0, 4'd0};
        tbl[6]  = '{4'd9, 4'd9, 4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 4'd9};
        tbl[7]  = '{4'd1, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 4'd0, 4'd9};
        tbl[8]  = '{4'd0, 4'd1, 4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 4'd9};
        tbl[9]  = '{4'd1, 4'd2, 4'hF, 4'd0, 1'b0, 1'b1, 4'd0, 4'd0};
        tbl[10] = '{4'd2, 4'd0, 4'd8, 4'd5, 1'b1, 1'b0, 4'd6, 4'd5};
        tbl[11] = '{4'd8, 4'd0, 4'd8, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0};
        bus.start  = 1'b0;
        bus.a_tens = 4'd0;
        bus.a_ones = 4'd0;
        bus.b_tens = 4'd0;
        bus.b_ones = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 0);
        check("rst_done", {31'b0, bus.done}, 0);
        check("rst_outs", {22'b0, bus.neg, bus.err, bus.tens, bus.ones}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) do_op(tbl[i], 1'b0);

        g = '{4'd6, 4'd2, 4'd1, 4'd8, 1'b0, 1'b0, 4'd4, 4'd4};
        do_op(g, 1'b1);
        repeat (3) @(negedge clk);
        check("hold_result", {24'b0, bus.tens, bus.ones}, 8'h44);
        check("hold_done", {31'b0, bus.done}, 0);

        bus.a_tens = 4'd6;
        bus.a_ones = 4'd2;
        bus.b_tens = 4'd1;
        bus.b_ones = 4'd8;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus.busy}, 0);
        check("abort_outs", {22'b0, bus.neg, bus.err, bus.tens, bus.ones}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        g = '{4'd7, 4'd1, 4'd2, 4'd9, 1'b0, 1'b0, 4'd4, 4'd2};
        do_op(g, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
